// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: issue, shared-multiplier and writeback signals of the
// M-extension sequencer.
// master = core side (execute stage, shared multiplier output, writeback)
// slave  = the sequencer itself
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic              issue_valid;
    logic [2:0]        issue_op;
    logic [XLEN-1:0]   issue_a;
    logic [XLEN-1:0]   issue_b;
    logic [4:0]        issue_rd;
    logic              flush;
    logic              mul_start;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic              mul_sa;
    logic              mul_sb;
    logic [2*XLEN-1:0] mul_prod;
    logic              stall;
    logic              busy;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              illegal;

    modport master (
        output issue_valid, issue_op, issue_a, issue_b, issue_rd, flush, mul_prod,
        input  mul_start, mul_a, mul_b, mul_sa, mul_sb, stall, busy,
               wb_valid, wb_rd, wb_data, illegal
    );

    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b, issue_rd, flush, mul_prod,
        output mul_start, mul_a, mul_b, mul_sa, mul_sb, stall, busy,
               wb_valid, wb_rd, wb_data, illegal
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: M-extension sequencer beside the execute stage.
// Launches the shared pipelined multiplier, runs a radix-2 restoring divider,
// stalls the front end while busy and emits one writeback beat per op.
// Build option MULDIV_DIV_EN: when defined the divider is included; when
// undefined every op>=4 completes in one cycle with illegal=1, wb_data=0.
//
// state    | meaning
// IDLE     | waiting; accepts an op when issue_valid and no flush
// MUL_WAIT | multiplier in flight, counting down to product capture
// DIV_RUN  | restoring divider, one quotient bit per cycle
// DONE     | writeback beat presented for exactly one cycle
module muldiv_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int XLEN    = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(((XLEN > MUL_LAT) ? XLEN : MUL_LAT) + 1);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} seqState;

    seqState          stateReg, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rdReg;
    logic [XLEN-1:0]  resultReg, mulAReg, mulBReg;
    logic             mulSaReg, mulSbReg, mulStartReg, mulLow, illegalReg;
    logic             accept;

    assign accept = (stateReg == IDLE) && bus.issue_valid && !bus.flush;

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] remReg, quoReg, divisorReg;
    logic            negQ, negR, divRem, divSpecial;
    logic            signedDiv, aNeg, bNeg, bZero, divOvf;
    logic [XLEN:0]   divShift, divDiff;

    // Classify divide operands at entry and form one restoring trial subtract.
    always_comb begin
        signedDiv = !bus.issue_op[0];
        aNeg      = signedDiv && bus.issue_a[XLEN-1];
        bNeg      = signedDiv && bus.issue_b[XLEN-1];
        bZero     = (bus.issue_b == '0);
        divOvf    = signedDiv && (bus.issue_a == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.issue_b == '1);
        divShift  = {remReg, quoReg[XLEN-1]};
        divDiff   = divShift - {1'b0, divisorReg};
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    // Next-state logic; flush in a busy state abandons the op without a beat.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    if (!bus.issue_op[2]) stateNext = MUL_WAIT;
`ifdef MULDIV_DIV_EN
                    else                  stateNext = DIV_RUN;
`else
                    else                  stateNext = DONE;
`endif
                end
            end
            MUL_WAIT: begin
                if (bus.flush)      stateNext = IDLE;
                else if (cnt == '0) stateNext = DONE;
            end
            DIV_RUN: begin
`ifdef MULDIV_DIV_EN
                if (bus.flush)                       stateNext = IDLE;
                else if (divSpecial || (cnt == '0)) stateNext = DONE;
`else
                stateNext = IDLE;
`endif
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Operand latch, multiplier launch, counters and divider datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            rdReg       <= '0;
            resultReg   <= '0;
            mulAReg     <= '0;
            mulBReg     <= '0;
            mulSaReg    <= 1'b0;
            mulSbReg    <= 1'b0;
            mulStartReg <= 1'b0;
            mulLow      <= 1'b0;
            illegalReg  <= 1'b0;
`ifdef MULDIV_DIV_EN
            remReg      <= '0;
            quoReg      <= '0;
            divisorReg  <= '0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            divRem      <= 1'b0;
            divSpecial  <= 1'b0;
`endif
        end else begin
            mulStartReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        rdReg      <= bus.issue_rd;
                        illegalReg <= 1'b0;
                        if (!bus.issue_op[2]) begin
                            mulAReg     <= bus.issue_a;
                            mulBReg     <= bus.issue_b;
                            mulSaReg    <= (bus.issue_op != 3'd3);
                            mulSbReg    <= !bus.issue_op[1];
                            mulLow      <= (bus.issue_op[1:0] == 2'b00);
                            mulStartReg <= 1'b1;
                            cnt         <= CNT_W'(MUL_LAT);
                        end else begin
`ifdef MULDIV_DIV_EN
                            divRem     <= bus.issue_op[1];
                            remReg     <= '0;
                            quoReg     <= aNeg ? -bus.issue_a : bus.issue_a;
                            divisorReg <= bNeg ? -bus.issue_b : bus.issue_b;
                            negQ       <= aNeg ^ bNeg;
                            negR       <= aNeg;
                            cnt        <= CNT_W'(XLEN);
                            divSpecial <= bZero || divOvf;
                            // Special cases resolve now; DIV_RUN only forwards them.
                            if (bZero)       resultReg <= bus.issue_op[1] ? bus.issue_a : '1;
                            else if (divOvf) resultReg <= bus.issue_op[1] ? '0 : bus.issue_a;
`else
                            resultReg  <= '0;
                            illegalReg <= 1'b1;
`endif
                        end
                    end
                end
                MUL_WAIT: begin
                    if (!bus.flush) begin
                        if (cnt != '0) cnt <= cnt - 1'b1;
                        else resultReg <= mulLow ? bus.mul_prod[XLEN-1:0]
                                                 : bus.mul_prod[2*XLEN-1:XLEN];
                    end
                end
                DIV_RUN: begin
`ifdef MULDIV_DIV_EN
                    if (!bus.flush && !divSpecial) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                            if (!divDiff[XLEN]) begin
                                remReg <= divDiff[XLEN-1:0];
                                quoReg <= {quoReg[XLEN-2:0], 1'b1};
                            end else begin
                                remReg <= divShift[XLEN-1:0];
                                quoReg <= {quoReg[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            resultReg <= divRem ? (negR ? -remReg : remReg)
                                                : (negQ ? -quoReg : quoReg);
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.mul_start = mulStartReg;
    assign bus.mul_a     = mulAReg;
    assign bus.mul_b     = mulBReg;
    assign bus.mul_sa    = mulSaReg;
    assign bus.mul_sb    = mulSbReg;
    assign bus.busy      = (stateReg != IDLE);
    assign bus.stall     = ((stateReg == IDLE) && bus.issue_valid)
                           || (stateReg == MUL_WAIT) || (stateReg == DIV_RUN);
    assign bus.wb_valid  = (stateReg == DONE);
    assign bus.wb_rd     = bus.wb_valid ? rdReg : 5'd0;
    assign bus.wb_data   = bus.wb_valid ? resultReg : '0;
    assign bus.illegal   = bus.wb_valid && illegalReg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer with a
// behavioural pipelined multiplier of latency MUL_LAT. Divide vectors are
// used when MULDIV_DIV_EN is defined, illegal-op vectors otherwise.
module tb_muldiv_sequencer;
    localparam int MUL_LAT = 2;
    localparam int XLEN    = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.MUL_LAT(MUL_LAT), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        int          issueCyc;
        int          lat;
    } sbEntry;

    sbEntry sbQ[$];
    sbEntry mon;
    int     cycNum    = 0;
    int     assertCnt = 0;
    int     failCnt   = 0;

    always @(posedge clk) cycNum <= cycNum + 1;

    // Shared multiplier stand-in: result appears MUL_LAT cycles after mul_start.
    function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    logic [64:0] mulPipe [MUL_LAT];
    always @(posedge clk) begin
        mulPipe[0] <= bus.mul_start ? {1'b1, mulModel(bus.mul_a, bus.mul_b, bus.mul_sa, bus.mul_sb)}
                                    : 65'd0;
        for (int i = 1; i < MUL_LAT; i++) mulPipe[i] <= mulPipe[i-1];
    end
    assign bus.mul_prod = mulPipe[MUL_LAT-1][64] ? mulPipe[MUL_LAT-1][63:0]
                                                 : 64'hDEAD_BEEF_CAFE_F00D;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int          ia, ib;
        logic [63:0] p;
        logic [31:0] res;
        logic        ovf;
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = 32'd0;
        p   = 64'd0;
        case (op)
            3'd0: begin p = 64'(longint'(ia) * longint'(ib)); res = p[31:0]; end
            3'd1: begin p = 64'(longint'(ia) * longint'(ib)); res = p[63:32]; end
            3'd2: begin p = 64'(longint'(ia) * longint'({32'b0, b})); res = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: res = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            3'd7: res = (b == 0) ? a : a % b;
`endif
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic int refLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return MUL_LAT + 2;
`ifdef MULDIV_DIV_EN
        if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
        return 34;
`else
        return 1;
`endif
    endfunction

    function automatic logic refIll(input logic [2:0] op);
`ifdef MULDIV_DIV_EN
        return 1'b0;
`else
        return op[2];
`endif
    endfunction

    // Writeback monitor: every beat must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (bus.wb_valid) begin
            if (sbQ.size() == 0) begin
                checkVal("spurious_wb", 64'(bus.wb_valid), 64'd0);
            end else begin
                mon = sbQ.pop_front();
                checkVal("wb_rd", 64'(bus.wb_rd), 64'(mon.rd));
                checkVal("wb_data", 64'(bus.wb_data), 64'(mon.data));
                checkVal("wb_illegal", 64'(bus.illegal), 64'(mon.ill));
                checkVal("wb_latency", 64'(cycNum - mon.issueCyc), 64'(mon.lat));
                checkVal("stall_done", 64'(bus.stall), 64'd0);
            end
        end
    end

    // Caller is just after a negedge with the sequencer idle.
    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] expData);
        sbEntry      e;
        logic [1:0]  expSign;
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_a     = a;
        bus.issue_b     = b;
        bus.issue_rd    = rd;
        e.rd       = rd;
        e.data     = expData;
        e.ill      = refIll(op);
        e.issueCyc = cycNum;
        e.lat      = refLat(op, a, b);
        sbQ.push_back(e);
        case (op)
            3'd0, 3'd1: expSign = 2'b11;
            3'd2:       expSign = 2'b10;
            default:    expSign = 2'b00;
        endcase
        #1;
        checkVal("stall_accept", 64'(bus.stall), 64'd1);
        checkVal("busy_accept", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.issue_a     = $urandom;
        bus.issue_b     = $urandom;
        bus.issue_op    = 3'($urandom);
        bus.issue_rd    = 5'($urandom);
        #1;
        if (op < 3'd4) begin
            checkVal("mul_start", 64'(bus.mul_start), 64'd1);
            checkVal("mul_sign", 64'({bus.mul_sa, bus.mul_sb}), 64'(expSign));
            checkVal("mul_ops", {bus.mul_a, bus.mul_b}, {a, b});
            checkVal("busy_mul", 64'(bus.busy), 64'd1);
        end else begin
            checkVal("mul_start_div", 64'(bus.mul_start), 64'd0);
        end
    endtask

    task automatic waitDone();
        for (int i = 0; i < 80 && sbQ.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbQ.size() != 0) begin
            checkVal("wb_timeout", 64'(sbQ.size()), 64'd0);
            sbQ.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_ctrl"}, 64'({bus.busy, bus.stall, bus.mul_start, bus.mul_sa, bus.mul_sb,
                                      bus.wb_valid, bus.illegal}), 64'd0);
        checkVal({tag, "_wb"}, 64'({bus.wb_rd, bus.wb_data}), 64'd0);
        checkVal({tag, "_mulops"}, {bus.mul_a, bus.mul_b}, 64'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_op    = 3'd0;
        bus.issue_a     = 32'd0;
        bus.issue_b     = 32'd0;
        bus.issue_rd    = 5'd0;
        bus.flush       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkAllZero("rst");
        @(negedge clk);
        reset = 1'b1;

        startOp(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);   waitDone();
        startOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE); waitDone();
        startOp(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000); waitDone();
        startOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF); waitDone();
        startOp(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd0, 32'h2345_6780); waitDone();
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            startOp(op, a, b, 5'($urandom), refResult(op, a, b));
            waitDone();
        end

        // Flush in the accept cycle: op is dropped.
        bus.issue_valid = 1'b1; bus.issue_op = 3'd0; bus.issue_a = 32'd3; bus.issue_b = 32'd4;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0; bus.flush = 1'b0;
        #1;
        checkVal("flush_accept_busy", 64'(bus.busy), 64'd0);
        checkVal("flush_accept_start", 64'(bus.mul_start), 64'd0);
        repeat (6) @(negedge clk);
        #1;

        // Flush in MUL_WAIT: no beat.
        startOp(3'd0, 32'd9, 32'd9, 5'd3, 32'd81);
        bus.flush = 1'b1;
        sbQ.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checkVal("flush_mul_busy", 64'(bus.busy), 64'd0);
        checkVal("flush_mul_stall", 64'(bus.stall), 64'd0);
        repeat (6) @(negedge clk);
        #1;

        // Flush in DONE: beat still fires.
        startOp(3'd0, 32'd3, 32'd5, 5'd9, 32'd15);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        #1 bus.flush = 1'b0;
        waitDone();

        // Reset mid multiply.
        startOp(3'd1, 32'h0000_1234, 32'h0000_5678, 5'd12, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checkAllZero("rst_mul");
        sbQ.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (MUL_LAT + 2) @(negedge clk);
        #1;

`ifdef MULDIV_DIV_EN
        startOp(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFA); waitDone();
        startOp(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFE); waitDone();
        startOp(3'd5, 32'd100, 32'd0, 5'd13, 32'hFFFF_FFFF);       waitDone();
        startOp(3'd7, 32'd100, 32'd0, 5'd13, 32'd100);             waitDone();
        startOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000); waitDone();
        startOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0); waitDone();
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(4, 7));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            startOp(op, a, b, 5'($urandom), refResult(op, a, b));
            waitDone();
        end

        // Flush DIV at cycle 10, new MUL accepted at cycle 11.
        startOp(3'd4, 32'd1000, 32'd7, 5'd15, 32'd142);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        sbQ.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checkVal("flush_div_busy", 64'(bus.busy), 64'd0);
        checkVal("flush_div_stall", 64'(bus.stall), 64'd0);
        startOp(3'd0, 32'd6, 32'd7, 5'd11, 32'd42);
        waitDone();

        // Reset in DIV_RUN cycle 5.
        startOp(3'd5, 32'd12345, 32'd17, 5'd16, 32'd0);
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checkAllZero("rst_div");
        sbQ.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
`else
        startOp(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'd0); waitDone();
        startOp(3'd4, 32'd100, 32'd5, 5'd11, 32'd0);       waitDone();
        startOp(3'd5, 32'd100, 32'd0, 5'd0, 32'd0);        waitDone();
        startOp(3'd7, 32'hDEAD_BEEF, 32'd9, 5'd31, 32'd0); waitDone();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
